// File: rtl/int_square.sv
// int_square: sequential shift-and-add squarer.
// A W-bit operand is captured on a go strobe in IDLE. W CALC iterations
// accumulate the partial products. The 2W-bit square is presented with a
// one-cycle done pulse. Latency is fixed at W+1 clocks from the go edge.
module int_square #(
    parameter int W = 10
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           go,
    input  logic [W-1:0]   x,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] sq
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_reg;
    state_t         state_next;

    logic [2*W-1:0] a_reg;
    logic [W-1:0]   b_reg;
    logic [2*W-1:0] acc_reg;
    logic [CW-1:0]  cnt_reg;
    logic [2*W-1:0] sq_reg;
    logic           done_reg;

    logic           last_iter;

    assign last_iter = (cnt_reg == LAST_ITER);

    // State register; an asynchronous clear aborts any operation in flight.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: a fixed W iterations, with no early exit on b == 0.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (go) state_next = S_CALC;
            S_CALC:  if (last_iter) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: load operands, then shift-and-add once per CALC cycle.
    // The result register and the done pulse are updated in DONE.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            a_reg    <= '0;
            b_reg    <= '0;
            acc_reg  <= '0;
            cnt_reg  <= '0;
            sq_reg   <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (go) begin
                        a_reg   <= {{W{1'b0}}, x};
                        b_reg   <= x;
                        acc_reg <= '0;
                        cnt_reg <= '0;
                    end
                end
                S_CALC: begin
                    // The sum of 2W bits cannot overflow: (2^W-1)^2 < 2^(2W).
                    if (b_reg[0]) begin
                        acc_reg <= acc_reg + a_reg;
                    end
                    a_reg   <= a_reg << 1;
                    b_reg   <= b_reg >> 1;
                    cnt_reg <= cnt_reg + 1'b1;
                end
                S_DONE: begin
                    sq_reg   <= acc_reg;
                    done_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs: busy also covers the cycle in which done is high.
    always_comb begin
        busy = (state_reg != S_IDLE) || done_reg;
        done = done_reg;
        sq   = sq_reg;
    end

endmodule

// File: tb/tb_int_square.sv
// Testbench for int_square (W = 10): directed vectors with literal results,
// plus a cycle-level reference that is checked against the DUT every cycle.
module tb_int_square;

    localparam int W = 10;
    localparam int LAT = W + 1;

    logic           clk = 1'b0;
    logic           clr = 1'b1;
    logic           go = 1'b0;
    logic [W-1:0]   x = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] sq;

    int errors = 0;
    int checks = 0;

    int_square #(.W(W)) dut (
        .clk  (clk),
        .clr  (clr),
        .go   (go),
        .x    (x),
        .busy (busy),
        .done (done),
        .sq   (sq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: an operation accepted at edge E completes at edge E+W+1
    // with result x*x. While one is outstanding, go is ignored.
    longint m_cyc = 0;
    longint m_go_cyc = 0;
    bit     m_active = 1'b0;
    bit     m_done = 1'b0;
    longint m_x = 0;
    longint m_sq = 0;
    bit     m_armed = 1'b0;

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_sq     = 0;
            m_armed  = 1'b1;
        end else begin
            m_cyc++;
            m_done = 1'b0;
            if (m_active && (m_cyc == m_go_cyc + LAT)) begin
                m_done   = 1'b1;
                m_sq     = m_x * m_x;
                m_active = 1'b0;
            end else if (!m_active && go) begin
                m_active = 1'b1;
                m_go_cyc = m_cyc;
                m_x      = longint'(x);
            end
        end
    end

    // Per-cycle comparison against the reference, once a reset has been seen.
    always @(negedge clk) begin
        if (m_armed) begin
            chk("model_done", longint'(done), longint'(m_done));
            chk("model_busy", longint'(busy), longint'(m_active || m_done));
            chk("model_sq", longint'(sq), m_sq);
        end
    end

    // Advance one clock; inputs are changed 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present one go strobe; returns just after edge T0.
    task automatic start(input logic [W-1:0] xv);
        go = 1'b1;
        x  = xv;
        tick();
        go = 1'b0;
    endtask

    // Wait for done (bounded) and check latency, result and pulse width.
    task automatic wait_done(input string name, input longint exp_sq, input int exp_lat);
        int lat;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done) begin
                lat = k;
                break;
            end
        end
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_sq"}, longint'(sq), exp_sq);
        tick();
        chk({name, "_done_width"}, longint'(done), 0);
        chk({name, "_busy_after"}, longint'(busy), 0);
    endtask

    initial begin
        // Reset: hold clr low for 3 cycles.
        #1 clr = 1'b0;
        repeat (3) tick();
        chk("reset_done", longint'(done), 0);
        chk("reset_busy", longint'(busy), 0);
        chk("reset_sq", longint'(sq), 0);
        clr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0 || sq !== '0)
                chk("idle_quiet", 1, 0);
        end
        chk("idle_busy", longint'(busy), 0);

        // Corner operands.
        start(10'd0);    wait_done("x0", 0, LAT);
        start(10'd1);    wait_done("x1", 1, LAT);
        start(10'd1023); wait_done("x1023", 1046529, LAT);

        // Mid-range; x is changed right after the go edge.
        start(10'd31);
        x = 10'd7;
        wait_done("x31", 961, LAT);
        repeat (5) tick();
        chk("sq_hold", longint'(sq), 961);
        start(10'd500);  wait_done("x500", 250000, LAT);

        // Back-to-back with go held high.
        begin
            int first;
            int second;
            first = 0;
            second = 0;
            go = 1'b1;
            x  = 10'd3;
            tick();
            x = 10'd100;
            for (int k = 1; k <= 40; k++) begin
                tick();
                if (done && first == 0) begin
                    first = k;
                    chk("b2b_sq1", longint'(sq), 9);
                end else if (done) begin
                    second = k;
                    go = 1'b0;
                    chk("b2b_sq2", longint'(sq), 10000);
                    break;
                end
            end
            go = 1'b0;
            chk("b2b_t1", first, 11);
            chk("b2b_t2", second, 23);
            tick();
            chk("b2b_done_end", longint'(done), 0);
            repeat (3) tick();
            chk("b2b_idle", longint'(busy), 0);
        end

        // Reset in the middle of a calculation.
        begin
            bit saw_done;
            saw_done = 1'b0;
            start(10'd1023);
            repeat (4) tick();
            @(posedge clk);
            #1 clr = 1'b0;
            #1;
            chk("abort_busy", longint'(busy), 0);
            chk("abort_sq", longint'(sq), 0);
            tick();
            tick();
            clr = 1'b1;
            for (int i = 0; i < 15; i++) begin
                tick();
                if (done) saw_done = 1'b1;
            end
            chk("abort_no_done", longint'(saw_done), 0);
            start(10'd12);
            wait_done("x12", 144, LAT);
        end

        // Exhaustive sweep.
        for (int v = 0; v < 1024; v++) begin
            start(v[W-1:0]);
            wait_done("sweep", longint'(v) * longint'(v), LAT);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/int_square.md
# int_square

Sequential shift-and-add integer squarer for the normalization datapath. It takes a W-bit unsigned operand on a go strobe and returns its 2W-bit square after a fixed number of cycles, with a one-cycle done pulse. Its go/done handshake matches the square-root unit. Its main use is squaring an integer root back, to form residues and run round-trip checks against the original 16-bit input.

## Interface
- W, default 10, operand width in bits; the result is 2W bits and one iteration runs per operand bit.
- clk  input  1  rising-edge clock, the only clock.
- clr  input  1  asynchronous, active-low reset (clr = 0 resets).
- go  input  1  start strobe, sampled only in IDLE.
- x  input  W  unsigned operand, captured on the go edge.
- busy  output  1  high from the go edge until the done cycle ends.
- done  output  1  one-cycle pulse; sq is valid in that cycle.
- sq  output  2W  unsigned result x*x, held until the next completion.

## Operation
- Datapath registers:
  - a: 2W bits, the shifted multiplicand.
  - b: W bits, the multiplier shift register.
  - acc: 2W bits, the accumulator.
  - cnt: ceil(log2(W+1)) bits, the iteration counter.
- IDLE:
  - go = 1 loads a = zero-extended x, b = x, acc = 0, cnt = 0, then moves to CALC.
  - go = 0 stays in IDLE.
- CALC, once per clock:
  - if b[0] = 1, acc <= acc + a; otherwise acc holds.
  - a <= a << 1, b <= b >> 1, cnt <= cnt + 1.
  - when cnt = W-1 (the last iteration), move to DONE.
- DONE: sq <= acc, done <= 1, then move to IDLE.
- Arithmetic is unsigned and acc cannot overflow, since (2^W - 1)^2 < 2^(2W). The adder is 2W bits wide and its carry-out is discarded (always 0).
- The iteration count is fixed at W. There is no early exit when b = 0, so latency does not depend on the data.
- go outside IDLE is ignored. Changes on x after the go edge have no effect.
- done and sq are registered outputs. busy is decoded from state (busy = state != IDLE) or registered; either way it follows the timing below.
- Reset (clr = 0), asynchronous and at any time, including mid-CALC:
  - state = IDLE; done = 0; busy = 0; sq = 0; a, b, acc, cnt = 0.
  - An aborted operation never raises done.

## Timing
- Edge T0 samples go = 1 in IDLE: operands load and busy = 1 from T0.
- Edges T0+1 through T0+W run the W CALC iterations. The last one (cnt = W-1) is at T0+W, with state moving to DONE.
- Edge T0+W+1: sq updates, done = 1 for that one cycle, and state returns to IDLE.
- Edge T0+W+2: done = 0 and busy = 0. If go = 1 here, the next operation starts, so back-to-back throughput is one result per W+2 cycles.
- Latency from the go edge to done rising is W+1 clocks (11 for W = 10).
- sq changes only at DONE edges and at reset.
- Reset release: the first edge with clr = 1 may accept go.

## Test plan
- Reset values: hold clr = 0 for 3 cycles, then release. Required: done = 0, busy = 0, sq = 0; with go = 0, the outputs stay at those values for 20 cycles.
- Corner operands (W = 10): x = 0 gives sq = 0; x = 1 gives sq = 1; x = 1023 gives sq = 1046529. Each done pulse is exactly 1 cycle and arrives exactly 11 clocks after the go edge.
- Mid-range and stability: x = 31 gives sq = 961 and x = 500 gives sq = 250000. Change x to 7 on the cycle after go: the result is still 961. sq holds 961 until the next done.
- Back-to-back: hold go = 1 continuously with x = 3 then x = 100, switching x after the first go edge. Required: done pulses at T0+11 and T0+23, with sq = 9 then sq = 10000. go asserted during CALC does not restart the operation.
- Reset mid-operation: start x = 1023, pull clr low at edge T0+5 for 2 cycles. Required: busy = 0 and sq = 0 immediately, and no done pulse. A subsequent x = 12 gives sq = 144.
- Exhaustive sweep: all x from 0 to 1023 against a reference model. Required: every sq = x*x and every latency = 11.
